// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch program-counter generator.
// Covers default widths and vectors, plus the controller state encoding.
package pc_gen_pkg;

  localparam int          PCG_XLEN     = 32;
  localparam logic [31:0] PCG_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PCG_TRAP_VEC = 32'h0000_0100;

  typedef enum logic [1:0] {
    PCG_BOOT = 2'd0,
    PCG_RUN  = 2'd1,
    PCG_HALT = 2'd2
  } pcg_state_e;

endpackage

// File: rtl/pc_gen_if.sv
// Instruction-fetch request channel between the PC generator and the instruction memory.
interface pc_gen_if
  import pc_gen_pkg::*;
#(
  parameter int XLEN = PCG_XLEN
);

  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;

  modport master (output if_valid, output if_pc, input if_ready);
  modport slave  (input if_valid, input if_pc, output if_ready);

endinterface

// File: rtl/pc_gen_target_sel.sv
// Redirect target selection: computes the branch, jalr and trap targets and applies priority.
// A misaligned branch or jalr target is replaced by the trap vector.
module pc_target_sel
  import pc_gen_pkg::*;
#(
  parameter int              XLEN       = PCG_XLEN,
  parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(PCG_TRAP_VEC),
  parameter int              ALIGN_BITS = 2
) (
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] imm,
  input  logic            jalr_taken,
  input  logic [XLEN-1:0] jalr_base,
  input  logic            trap_taken,
  input  logic [XLEN-1:0] trap_pc,
  output logic            redirect,
  output logic [XLEN-1:0] target,
  output logic            misalign
);

  logic [XLEN-1:0] br_tgt_s;
  logic [XLEN-1:0] jalr_tgt_s;
  logic [XLEN-1:0] sel_tgt_s;
  logic            check_align_s;
  logic            bad_align_s;

  assign br_tgt_s   = br_pc + imm;
  assign jalr_tgt_s = (jalr_base + imm) & ~{{(XLEN-1){1'b0}}, 1'b1};

  // Priority mux; only branch and jalr targets are subject to the alignment check.
  always_comb begin
    sel_tgt_s     = br_tgt_s;
    check_align_s = 1'b0;
    if (trap_taken) begin
      sel_tgt_s     = trap_pc;
      check_align_s = 1'b0;
    end else if (jalr_taken) begin
      sel_tgt_s     = jalr_tgt_s;
      check_align_s = 1'b1;
    end else if (br_taken) begin
      sel_tgt_s     = br_tgt_s;
      check_align_s = 1'b1;
    end else begin
      sel_tgt_s     = br_tgt_s;
      check_align_s = 1'b0;
    end
  end

  assign bad_align_s = check_align_s && (|sel_tgt_s[ALIGN_BITS-1:0]);
  assign redirect    = trap_taken | jalr_taken | br_taken;
  assign target      = bad_align_s ? TRAP_VEC : sel_tgt_s;
  assign misalign    = bad_align_s;

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator: owns the architectural PC and drives the fetch request.
// if_valid and if_pc come only from registers, so they never depend on if_ready.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN       = PCG_XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(PCG_RESET_PC),
  parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(PCG_TRAP_VEC),
  parameter int              STEP       = 4,
  parameter int              ALIGN_BITS = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            halt,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] imm,
  input  logic            jalr_taken,
  input  logic [XLEN-1:0] jalr_base,
  input  logic            trap_taken,
  input  logic [XLEN-1:0] trap_pc,
  pc_gen_if.master        fetch,
  output logic            misalign,
  output logic            halted
);

  pcg_state_e      state_r;
  pcg_state_e      next_state_s;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_next_s;
  logic            misalign_r;
  logic            redirect_s;
  logic [XLEN-1:0] target_s;
  logic            target_bad_s;

  pc_target_sel #(
    .XLEN      (XLEN),
    .TRAP_VEC  (TRAP_VEC),
    .ALIGN_BITS(ALIGN_BITS)
  ) u_target_sel (
    .br_taken  (br_taken),
    .br_pc     (br_pc),
    .imm       (imm),
    .jalr_taken(jalr_taken),
    .jalr_base (jalr_base),
    .trap_taken(trap_taken),
    .trap_pc   (trap_pc),
    .redirect  (redirect_s),
    .target    (target_s),
    .misalign  (target_bad_s)
  );

  // State, PC and misalign-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= PCG_BOOT;
      pc_r       <= RESET_PC;
      misalign_r <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      pc_r       <= pc_next_s;
      misalign_r <= target_bad_s;
    end
  end

  // Next state; a redirect in RUN postpones entry into HALT by a cycle.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      PCG_BOOT: next_state_s = PCG_RUN;
      PCG_RUN: begin
        if (halt && !redirect_s) begin
          next_state_s = PCG_HALT;
        end else begin
          next_state_s = PCG_RUN;
        end
      end
      PCG_HALT: begin
        if (halt) begin
          next_state_s = PCG_HALT;
        end else begin
          next_state_s = PCG_RUN;
        end
      end
      default: next_state_s = PCG_BOOT;
    endcase
  end

  // Next PC: redirect wins over an accepted fetch; otherwise hold.
  always_comb begin
    pc_next_s = pc_r;
    if (redirect_s) begin
      pc_next_s = target_s;
    end else if ((state_r == PCG_RUN) && fetch.if_ready) begin
      pc_next_s = pc_r + XLEN'(STEP);
    end else begin
      pc_next_s = pc_r;
    end
  end

  assign fetch.if_valid = (state_r == PCG_RUN);
  assign fetch.if_pc    = pc_r;
  assign halted         = (state_r == PCG_HALT);
  assign misalign       = misalign_r;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a cycle-level reference model checked every cycle,
// plus hand-computed literal expectations along the directed sequence.
module tb_pc_gen;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] TVEC   = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic        br_taken;
  logic [31:0] br_pc;
  logic [31:0] imm;
  logic        jalr_taken;
  logic [31:0] jalr_base;
  logic        trap_taken;
  logic [31:0] trap_pc;
  logic        misalign;
  logic        halted;

  int checks = 0;
  int errors = 0;

  pc_gen_if #(.XLEN(32)) fif ();

  pc_gen dut (
    .clk       (clk),
    .rst       (rst),
    .halt      (halt),
    .br_taken  (br_taken),
    .br_pc     (br_pc),
    .imm       (imm),
    .jalr_taken(jalr_taken),
    .jalr_base (jalr_base),
    .trap_taken(trap_taken),
    .trap_pc   (trap_pc),
    .fetch     (fif.master),
    .misalign  (misalign),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 = booting, 1 = fetching, 2 = halted.
  int          m_mode;
  logic [31:0] m_pc;
  logic        m_mis;
  logic        m_live = 1'b0;

  // Returns {misaligned, chosen target} following the redirect rules.
  function automatic logic [32:0] model_redirect();
    logic [31:0] t;
    if (trap_taken) return {1'b0, trap_pc};
    if (jalr_taken) t = (jalr_base + imm) & 32'hFFFF_FFFE;
    else            t = br_pc + imm;
    if (t % 32'd4 != 32'd0) return {1'b1, TVEC};
    return {1'b0, t};
  endfunction

  always @(posedge clk) begin
    logic        any;
    logic [32:0] r;
    any = trap_taken | jalr_taken | br_taken;
    r   = model_redirect();
    if (rst) begin
      m_live <= 1'b1;
      m_mode <= 0;
      m_pc   <= RST_PC;
      m_mis  <= 1'b0;
    end else begin
      m_mis <= any & r[32];
      if (any)                               m_pc <= r[31:0];
      else if (m_mode == 1 && fif.if_ready)  m_pc <= m_pc + 32'd4;
      if (m_mode == 0)      m_mode <= 1;
      else if (m_mode == 1) m_mode <= (halt && !any) ? 2 : 1;
      else                  m_mode <= halt ? 2 : 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      chk("model_if_valid", {31'd0, fif.if_valid}, {31'd0, m_mode == 1});
      chk("model_if_pc", fif.if_pc, m_pc);
      chk("model_halted", {31'd0, halted}, {31'd0, m_mode == 2});
      chk("model_misalign", {31'd0, misalign}, {31'd0, m_mis});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redirects();
    br_taken = 1'b0; jalr_taken = 1'b0; trap_taken = 1'b0;
  endtask

  task automatic lit(input string name, input logic v, input logic [31:0] pc,
                     input logic h, input logic m);
    chk({name, "_valid"}, {31'd0, fif.if_valid}, {31'd0, v});
    chk({name, "_pc"}, fif.if_pc, pc);
    chk({name, "_halted"}, {31'd0, halted}, {31'd0, h});
    chk({name, "_misalign"}, {31'd0, misalign}, {31'd0, m});
  endtask

  initial begin
    rst = 1'b1; halt = 1'b0; fif.if_ready = 1'b0;
    br_pc = 32'd0; imm = 32'd0; jalr_base = 32'd0; trap_pc = 32'd0;
    clear_redirects();
    cyc(); cyc();
    rst = 1'b0; fif.if_ready = 1'b1;
    lit("boot", 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(); lit("seq0", 1'b1, 32'h0, 1'b0, 1'b0);
    cyc(); lit("seq4", 1'b1, 32'h4, 1'b0, 1'b0);
    cyc(); lit("seq8", 1'b1, 32'h8, 1'b0, 1'b0);
    cyc(); lit("seqC", 1'b1, 32'hC, 1'b0, 1'b0);
    cyc(); lit("seq10", 1'b1, 32'h10, 1'b0, 1'b0);
    // Stall
    fif.if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(); lit("stall", 1'b1, 32'h10, 1'b0, 1'b0);
    end
    fif.if_ready = 1'b1;
    cyc(); lit("unstall", 1'b1, 32'h14, 1'b0, 1'b0);
    // jalr beats branch, bit 0 cleared
    br_taken = 1'b1; br_pc = 32'h20; jalr_taken = 1'b1; jalr_base = 32'h101; imm = 32'h10;
    cyc(); clear_redirects();
    lit("jalr_prio", 1'b1, 32'h110, 1'b0, 1'b0);
    // trap beats branch
    trap_taken = 1'b1; trap_pc = 32'h800; br_taken = 1'b1; br_pc = 32'h20; imm = 32'h40;
    cyc(); clear_redirects();
    lit("trap_prio", 1'b1, 32'h800, 1'b0, 1'b0);
    // misaligned branch target
    br_taken = 1'b1; br_pc = 32'h20; imm = 32'h2;
    cyc(); clear_redirects();
    lit("mis_br", 1'b1, TVEC, 1'b0, 1'b1);
    cyc(); lit("mis_pulse_end", 1'b1, 32'h104, 1'b0, 1'b0);
    // misaligned trap target is not checked
    trap_taken = 1'b1; trap_pc = 32'h302;
    cyc(); clear_redirects();
    lit("trap_unchecked", 1'b1, 32'h302, 1'b0, 1'b0);
    // redirect during stall overrides the pending request
    fif.if_ready = 1'b0; br_taken = 1'b1; br_pc = 32'h100; imm = 32'h4;
    cyc(); clear_redirects();
    lit("stall_redirect", 1'b1, 32'h104, 1'b0, 1'b0);
    // halt during stall
    halt = 1'b1;
    cyc(); lit("halt_enter", 1'b0, 32'h104, 1'b1, 1'b0);
    br_taken = 1'b1; br_pc = 32'h1F0; imm = 32'h10;
    cyc(); clear_redirects();
    lit("halt_redirect", 1'b0, 32'h200, 1'b1, 1'b0);
    cyc(); lit("halt_hold", 1'b0, 32'h200, 1'b1, 1'b0);
    halt = 1'b0;
    cyc(); lit("halt_release", 1'b1, 32'h200, 1'b0, 1'b0);
    // halt with handshake in the same cycle
    fif.if_ready = 1'b1; halt = 1'b1;
    cyc(); lit("halt_hs", 1'b0, 32'h204, 1'b1, 1'b0);
    halt = 1'b0;
    cyc(); lit("halt_hs_release", 1'b1, 32'h204, 1'b0, 1'b0);
    // misaligned jalr (bit 1 survives the bit-0 clear)
    jalr_taken = 1'b1; jalr_base = 32'h3; imm = 32'h0;
    cyc(); clear_redirects();
    lit("mis_jalr", 1'b1, TVEC, 1'b0, 1'b1);
    // wrap-around of both target adder and sequential increment
    jalr_taken = 1'b1; jalr_base = 32'hFFFF_FFF0; imm = 32'h0000_000C;
    cyc(); clear_redirects();
    lit("wrap_pre", 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    cyc(); lit("wrap", 1'b1, 32'h0, 1'b0, 1'b0);
    br_taken = 1'b1; br_pc = 32'h8; imm = 32'hFFFF_FFF8;
    cyc(); clear_redirects();
    lit("neg_imm", 1'b1, 32'h0, 1'b0, 1'b0);
    // reset during a stall
    fif.if_ready = 1'b0;
    cyc(); cyc();
    rst = 1'b1; br_taken = 1'b1; br_pc = 32'h40; imm = 32'h0;
    cyc(); clear_redirects();
    lit("rst_stall", 1'b0, RST_PC, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(); lit("reboot", 1'b1, RST_PC, 1'b0, 1'b0);
    cyc(); cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
